nvme_doorbell_arbiter: RTL and testbench

- Shares the single doorbell write engine (write_sqtdbl / write_cqhdbl request, done handshake) among NUM_Q NVMe queue pairs.
- Each queue pair posts SQ-tail and CQ-head updates. The block coalesces repeat updates per doorbell and arbitrates round-robin across the 2*NUM_Q doorbell slots.
- It issues one doorbell write at a time, with the computed BAR0 offset and value.
- Sits between the per-queue command/completion logic and the doorbell writer. Enabled by the NVMe controller once configuration completes.

---
 rtl/nvme_doorbell_arbiter.sv | 166 ++++++++++++++++
 tb/tb_nvme_doorbell_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_doorbell_arbiter.sv
// Round-robin doorbell arbiter: coalesces SQ-tail/CQ-head updates per slot and issues one write at a time.
// Strobe-to-request latency 2 cycles; stalls in WAIT until the matching done (bounded by a watchdog under DB_ARB_TIMEOUT_EN).
module nvme_doorbell_arbiter #(
  parameter int          NUM_Q   = 4,
  parameter logic [63:0] DB_BASE = 64'h1000,
  parameter int          DSTRD   = 0,
  parameter int          VAL_W   = 16
) (
  input  logic                     user_clk,
  input  logic                     user_reset_n,
  input  logic                     en,
  input  logic [NUM_Q-1:0]         sq_upd,
  input  logic [NUM_Q*VAL_W-1:0]   sq_tail,
  input  logic [NUM_Q-1:0]         cq_upd,
  input  logic [NUM_Q*VAL_W-1:0]   cq_head,
  output logic                     write_sqtdbl,
  output logic [63:0]              sqt_addr,
  output logic                     write_cqhdbl,
  output logic [63:0]              cqh_addr,
  output logic [31:0]              db_value,
  input  logic                     write_sqtdbl_done,
  input  logic                     write_cqhdbl_done,
  output logic                     busy,
`ifdef DB_ARB_TIMEOUT_EN
  output logic                     db_timeout,
`endif
  output logic [2*NUM_Q-1:0]       pending
);

  localparam int NS = 2 * NUM_Q;
  localparam int SW = $clog2(NS);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t           r_state;
  logic [NS-1:0]    r_pending;
  logic [VAL_W-1:0] r_value [NS];
  logic [SW-1:0]    r_rr_ptr;
  logic [SW-1:0]    r_gnt_slot;

  logic             w_gnt_vld;
  logic [SW-1:0]    w_gnt_slot;
  logic             w_grant;
  logic             w_done;
  logic             w_retry;
  logic [63:0]      w_addr;
  logic [NS-1:0]    w_set;
  logic [NS-1:0]    w_clr;
  logic [NS-1:0]    w_rset;

  function automatic logic [SW-1:0] wrap_slot(input int s);
    return SW'((s >= NS) ? s - NS : s);
  endfunction

  // Lowest offset from rr_ptr wins: scan downward so the nearest pending slot overwrites.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_slot = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (r_pending[wrap_slot(int'(r_rr_ptr) + i)]) begin
        w_gnt_vld  = 1'b1;
        w_gnt_slot = wrap_slot(int'(r_rr_ptr) + i);
      end
    end
  end

  always_comb begin
    w_set = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      w_set[2*q]   = sq_upd[q];
      w_set[2*q+1] = cq_upd[q];
    end
  end

  assign w_grant = (r_state == ST_IDLE) && en && w_gnt_vld;
  assign w_done  = (r_state == ST_WAIT) &&
                   (r_gnt_slot[0] ? write_cqhdbl_done : write_sqtdbl_done);
  assign w_addr  = DB_BASE + (64'(w_gnt_slot) << (2 + DSTRD));
  assign w_clr   = w_grant ? (NS'(1) << w_gnt_slot) : '0;
  assign w_rset  = w_retry ? (NS'(1) << r_gnt_slot) : '0;
  assign busy    = (r_state != ST_IDLE);
  assign pending = r_pending;

`ifdef DB_ARB_TIMEOUT_EN
  logic [15:0] r_wdog;
  assign w_retry = (r_state == ST_WAIT) && !w_done && (r_wdog == 16'hFFFF);
`else
  assign w_retry = 1'b0;
`endif

  // A strobe landing on the slot being granted keeps it pending with the newer value.
  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_pending <= '0;
      for (int s = 0; s < NS; s++) r_value[s] <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set | w_rset;
      for (int q = 0; q < NUM_Q; q++) begin
        if (sq_upd[q]) r_value[2*q]   <= sq_tail[q*VAL_W +: VAL_W];
        if (cq_upd[q]) r_value[2*q+1] <= cq_head[q*VAL_W +: VAL_W];
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_gnt_slot   <= '0;
      write_sqtdbl <= 1'b0;
      write_cqhdbl <= 1'b0;
      sqt_addr     <= '0;
      cqh_addr     <= '0;
      db_value     <= '0;
`ifdef DB_ARB_TIMEOUT_EN
      r_wdog       <= '0;
      db_timeout   <= 1'b0;
`endif
    end else begin
      write_sqtdbl <= 1'b0;
      write_cqhdbl <= 1'b0;
`ifdef DB_ARB_TIMEOUT_EN
      db_timeout   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_gnt_slot <= w_gnt_slot;
            db_value   <= 32'(r_value[w_gnt_slot]);
            if (w_gnt_slot[0]) cqh_addr <= w_addr;
            else               sqt_addr <= w_addr;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          write_sqtdbl <= !r_gnt_slot[0];
          write_cqhdbl <= r_gnt_slot[0];
          r_rr_ptr     <= wrap_slot(int'(r_gnt_slot) + 1);
`ifdef DB_ARB_TIMEOUT_EN
          r_wdog       <= '0;
`endif
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_done) begin
            sqt_addr <= '0;
            cqh_addr <= '0;
            r_state  <= ST_IDLE;
          end
`ifdef DB_ARB_TIMEOUT_EN
          else if (w_retry) begin
            sqt_addr   <= '0;
            cqh_addr   <= '0;
            db_timeout <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvme_doorbell_arbiter.sv
// Scoreboard bench for nvme_doorbell_arbiter: expected writes queued at stimulus, popped when a request appears.
module tb_nvme_doorbell_arbiter;

  localparam int NUM_Q = 4;
  localparam int VAL_W = 16;

  logic                   user_clk = 1'b0;
  logic                   user_reset_n = 1'b0;
  logic                   en = 1'b0;
  logic [NUM_Q-1:0]       sq_upd = '0;
  logic [NUM_Q-1:0]       cq_upd = '0;
  logic [NUM_Q*VAL_W-1:0] sq_tail = '0;
  logic [NUM_Q*VAL_W-1:0] cq_head = '0;
  logic                   write_sqtdbl, write_cqhdbl, busy;
  logic [63:0]            sqt_addr, cqh_addr;
  logic [31:0]            db_value;
  logic [2*NUM_Q-1:0]     pending;
  logic                   auto_sq, auto_cq, man_sq, man_cq;
  logic                   write_sqtdbl_done, write_cqhdbl_done;
`ifdef DB_ARB_TIMEOUT_EN
  logic                   db_timeout;
`endif

  assign write_sqtdbl_done = auto_sq | man_sq;
  assign write_cqhdbl_done = auto_cq | man_cq;

  always #5 user_clk = ~user_clk;

  nvme_doorbell_arbiter #(.NUM_Q(NUM_Q), .DB_BASE(64'h1000), .DSTRD(0), .VAL_W(VAL_W)) dut (
    .user_clk(user_clk), .user_reset_n(user_reset_n), .en(en),
    .sq_upd(sq_upd), .sq_tail(sq_tail), .cq_upd(cq_upd), .cq_head(cq_head),
    .write_sqtdbl(write_sqtdbl), .sqt_addr(sqt_addr),
    .write_cqhdbl(write_cqhdbl), .cqh_addr(cqh_addr), .db_value(db_value),
    .write_sqtdbl_done(write_sqtdbl_done), .write_cqhdbl_done(write_cqhdbl_done),
    .busy(busy),
`ifdef DB_ARB_TIMEOUT_EN
    .db_timeout(db_timeout),
`endif
    .pending(pending)
  );

  typedef struct packed {
    logic        cq;
    logic [63:0] addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   resp_en = 1'b1;
  bit   r_t;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input int slot, input int val);
    exp_t e;
    e.cq   = slot[0];
    e.addr = 64'h1000 + 64'(slot) * 64'd4;
    e.val  = 32'(val);
    return e;
  endfunction

  task automatic expect_wr(input int slot, input int val);
    sb.push_back(mk(slot, val));
  endtask

  task automatic set_upd(input int slot, input int val);
    int q = slot / 2;
    if (slot % 2 == 1) begin
      cq_upd[q] = 1'b1;
      cq_head[q*VAL_W +: VAL_W] = VAL_W'(val);
    end else begin
      sq_upd[q] = 1'b1;
      sq_tail[q*VAL_W +: VAL_W] = VAL_W'(val);
    end
  endtask

  task automatic tick();
    @(posedge user_clk); #1;
    sq_upd = '0;
    cq_upd = '0;
  endtask

  task automatic post(input int slot, input int val);
    set_upd(slot, val);
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || pending != '0 || sb.size() != 0) && n < budget) begin
      @(negedge user_clk);
      n++;
    end
    check_eq({tag, "_drained"}, 64'(n < budget), 64'd1);
    check_eq({tag, "_sqt_addr_clr"}, sqt_addr, 64'd0);
    check_eq({tag, "_cqh_addr_clr"}, cqh_addr, 64'd0);
    @(posedge user_clk); #1;
  endtask

  // Write monitor: every request must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge user_clk);
      if (write_sqtdbl || write_cqhdbl) begin
        check_eq("single_req", 64'(write_sqtdbl & write_cqhdbl), 64'd0);
        check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check_eq("wr_type", 64'(write_cqhdbl), 64'(e.cq));
          check_eq("wr_addr", write_cqhdbl ? cqh_addr : sqt_addr, e.addr);
          check_eq("wr_other_addr", write_cqhdbl ? sqt_addr : cqh_addr, 64'd0);
          check_eq("wr_value", 64'(db_value), 64'(e.val));
        end
      end
    end
  end

  // Writer model: completes each request three cycles later when enabled.
  initial begin
    auto_sq = 1'b0;
    auto_cq = 1'b0;
    forever begin
      @(negedge user_clk);
      if (resp_en && (write_sqtdbl || write_cqhdbl)) begin
        r_t = write_cqhdbl;
        repeat (3) @(posedge user_clk);
        #1;
        if (r_t) auto_cq = 1'b1;
        else     auto_sq = 1'b1;
        @(posedge user_clk); #1;
        auto_sq = 1'b0;
        auto_cq = 1'b0;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running, required to have finished");
    $fatal(1);
  end

  initial begin
    man_sq = 1'b0;
    man_cq = 1'b0;
    repeat (3) @(posedge user_clk);
    #1;
    check_eq("rst_write_sq", 64'(write_sqtdbl), 64'd0);
    check_eq("rst_write_cq", 64'(write_cqhdbl), 64'd0);
    check_eq("rst_sqt_addr", sqt_addr, 64'd0);
    check_eq("rst_cqh_addr", cqh_addr, 64'd0);
    check_eq("rst_db_value", 64'(db_value), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_pending", 64'(pending), 64'd0);
    user_reset_n = 1'b1;
    en = 1'b1;
    @(posedge user_clk); #1;

    // SQ0 tail 5: latency and address
    expect_wr(0, 5);
    post(0, 5);
    @(negedge user_clk);
    check_eq("t1_c0_pending", 64'(pending), 64'h01);
    check_eq("t1_c0_req", 64'(write_sqtdbl), 64'd0);
    @(negedge user_clk);
    check_eq("t1_c1_req", 64'(write_sqtdbl), 64'd0);
    check_eq("t1_c1_busy", 64'(busy), 64'd1);
    @(negedge user_clk);
    check_eq("t1_c2_req", 64'(write_sqtdbl), 64'd1);
    check_eq("t1_c2_addr", sqt_addr, 64'h1000);
    check_eq("t1_c2_value", 64'(db_value), 64'd5);
    wait_idle("t1", 50);

    // CQ2 head 7
    expect_wr(5, 7);
    post(5, 7);
    wait_idle("t2", 50);

    // Reset while a write is outstanding drops everything
    resp_en = 1'b0;
    expect_wr(6, 33);
    post(6, 33);
    repeat (4) @(negedge user_clk);
    set_upd(7, 44);
    tick();
    @(negedge user_clk);
    check_eq("rst_mid_busy_before", 64'(busy), 64'd1);
    check_eq("rst_mid_pending_before", 64'(pending), 64'h80);
    #2;
    user_reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    check_eq("rst_mid_pending", 64'(pending), 64'd0);
    check_eq("rst_mid_sqt_addr", sqt_addr, 64'd0);
    check_eq("rst_mid_cqh_addr", cqh_addr, 64'd0);
    check_eq("rst_mid_db_value", 64'(db_value), 64'd0);
    repeat (2) @(posedge user_clk);
    #1;
    user_reset_n = 1'b1;
    resp_en = 1'b1;
    repeat (10) @(negedge user_clk);
    check_eq("rst_mid_lost_pending", 64'(pending), 64'd0);
    check_eq("rst_mid_lost_busy", 64'(busy), 64'd0);
    @(posedge user_clk); #1;

    // All eight slots at once from rr_ptr 0
    for (int s = 0; s < 8; s++) begin
      expect_wr(s, 100 + s);
      set_upd(s, 100 + s);
    end
    tick();
    wait_idle("t3_all", 300);

    // Next pass starts after the last grant: SQ1 moves rr_ptr to 3, so slot 5 beats slot 0
    expect_wr(2, 50);
    post(2, 50);
    wait_idle("t3_rr_a", 50);
    expect_wr(5, 61);
    expect_wr(0, 60);
    set_upd(0, 60);
    set_upd(5, 61);
    tick();
    wait_idle("t3_rr_b", 100);

    // Coalescing: SQ1 updated three times while SQ0 waits
    expect_wr(0, 20);
    post(0, 20);
    @(posedge user_clk); #1;
    @(posedge user_clk); #1;
    expect_wr(2, 9);
    post(2, 3);
    post(2, 4);
    post(2, 9);
    wait_idle("t4", 100);

    // Strobe on the grant cycle re-arms the slot
    expect_wr(0, 11);
    expect_wr(0, 12);
    post(0, 11);
    post(0, 12);
    wait_idle("t5", 100);

    // en low: in-flight write finishes, no new grant
    expect_wr(1, 70);
    set_upd(1, 70);
    set_upd(3, 71);
    tick();
    @(posedge user_clk); #1;
    en = 1'b0;
    repeat (12) @(negedge user_clk);
    check_eq("t6_en_pending", 64'(pending), 64'h08);
    check_eq("t6_en_busy", 64'(busy), 64'd0);
    expect_wr(3, 71);
    en = 1'b1;
    wait_idle("t6", 100);

    // Done in ISSUE and a mismatched done are both ignored
    resp_en = 1'b0;
    expect_wr(4, 80);
    post(4, 80);
    man_sq = 1'b1;
    @(posedge user_clk); #1;
    man_sq = 1'b0;
    man_cq = 1'b1;
    @(posedge user_clk); #1;
    man_cq = 1'b0;
    @(negedge user_clk);
    check_eq("t7_busy_held", 64'(busy), 64'd1);
    check_eq("t7_addr_held", sqt_addr, 64'h1010);
    check_eq("t7_value_held", 64'(db_value), 64'd80);
    @(posedge user_clk); #1;
    man_sq = 1'b1;
    @(posedge user_clk); #1;
    man_sq = 1'b0;
    @(negedge user_clk);
    check_eq("t7_busy_released", 64'(busy), 64'd0);
    check_eq("t7_addr_cleared", sqt_addr, 64'd0);
    resp_en = 1'b1;
    @(posedge user_clk); #1;

`ifdef DB_ARB_TIMEOUT_EN
    begin
      int n = 0;
      resp_en = 1'b0;
      expect_wr(0, 90);
      expect_wr(0, 90);
      post(0, 90);
      while (!db_timeout && n < 70000) begin
        @(negedge user_clk);
        n++;
      end
      check_eq("tmo_seen", 64'(db_timeout), 64'd1);
      resp_en = 1'b1;
      @(negedge user_clk);
      check_eq("tmo_one_cycle", 64'(db_timeout), 64'd0);
      wait_idle("tmo_retry", 100);
    end
`endif

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
